// File: rtl/logic_op_pkg.sv
// Shared opcodes and widths for the time-shared bitwise logic unit and its arbiter.
package logic_op_pkg;
    localparam logic [1:0] OP_NOT  = 2'b00;
    localparam logic [1:0] OP_AND  = 2'b01;
    localparam logic [1:0] OP_OR   = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    localparam int ID_W  = 2;
    localparam int CNT_W = 16;

    typedef logic [ID_W-1:0] req_id_t;
endpackage

// File: rtl/logic_op_arbiter_if.sv
// Request/result bundle between requesters (master) and the logic-op arbiter (slave).
interface logic_op_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
);
    import logic_op_pkg::*;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [2*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_a;
    logic [WIDTH*NREQ-1:0] req_b;
    logic                  res_valid;
    logic                  res_ready;
    logic [WIDTH-1:0]      res_data;
    req_id_t               res_id;

    modport master (
        output req_valid, req_op, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_data, res_id
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, res_ready,
        output req_ready, res_valid, res_data, res_id
    );
endinterface

// File: rtl/logic_op_arbiter_blu.sv
// Bitwise NOT/AND/OR/NAND unit built from per-bit gate cells with a 4:1 output select.
// Purely combinational: zero latency, no flow control.
module inverter (
    input  logic a,
    output logic y
);
    assign y = ~a;
endmodule

module andgate (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a & b;
endmodule

module orgate (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a | b;
endmodule

module nandgate (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = ~(a & b);
endmodule

module bitwise_logic_unit
    import logic_op_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    logic [WIDTH-1:0] not_y;
    logic [WIDTH-1:0] and_y;
    logic [WIDTH-1:0] or_y;
    logic [WIDTH-1:0] nand_y;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        inverter u_inv  (.a(a[i]),            .y(not_y[i]));
        andgate  u_and  (.a(a[i]), .b(b[i]), .y(and_y[i]));
        orgate   u_or   (.a(a[i]), .b(b[i]), .y(or_y[i]));
        nandgate u_nand (.a(a[i]), .b(b[i]), .y(nand_y[i]));
    end

    always_comb begin
        y = not_y;
        case (op)
            OP_NOT:  y = not_y;
            OP_AND:  y = and_y;
            OP_OR:   y = or_y;
            OP_NAND: y = nand_y;
        endcase
    end
endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit among four requesters; 1-cycle latency.
// A result stalled by res_ready=0 holds its register and drops every req_ready to 0.
module logic_op_arbiter
    import logic_op_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    logic_op_arbiter_if.slave bus,
    output logic [CNT_W-1:0] txn_count
);
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q,  res_data_d;
    req_id_t          res_id_q,    res_id_d;
    req_id_t          last_grant_q, last_grant_d;
    logic [CNT_W-1:0] txn_count_q, txn_count_d;

    req_id_t          ptr;
    logic [NREQ-1:0]  rot_vld;
    req_id_t          pick;
    req_id_t          win;
    logic             found;
    logic             accept;
    logic             xfer;
    logic [NREQ-1:0]  grant;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] blu_y;

    // Rotate so the requester after last_grant sits at bit 0, pick lowest, then un-rotate.
    always_comb begin
        ptr     = last_grant_q + 2'd1;
        rot_vld = '0;
        pick    = '0;
        found   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            rot_vld[k] = bus.req_valid[ptr + req_id_t'(k)];
        end
        for (int k = 0; k < NREQ; k++) begin
            if (!found && rot_vld[k]) begin
                found = 1'b1;
                pick  = req_id_t'(k);
            end
        end
        win = ptr + pick;
    end

    always_comb begin
        accept = !res_valid_q || bus.res_ready;
        xfer   = found && accept;
        grant  = '0;
        if (found) begin
            grant[win] = 1'b1;
        end
        bus.req_ready = (rst_n && accept) ? grant : '0;
        sel_op = bus.req_op[2*win +: 2];
        sel_a  = bus.req_a[WIDTH*win +: WIDTH];
        sel_b  = bus.req_b[WIDTH*win +: WIDTH];
    end

    bitwise_logic_unit #(.WIDTH(WIDTH)) u_blu (
        .op(sel_op),
        .a (sel_a),
        .b (sel_b),
        .y (blu_y)
    );

    always_comb begin
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_id_d     = res_id_q;
        last_grant_d = last_grant_q;
        txn_count_d  = txn_count_q;
        if (xfer) begin
            res_valid_d  = 1'b1;
            res_data_d   = blu_y;
            res_id_d     = win;
            last_grant_d = win;
        end else if (bus.res_ready) begin
            res_valid_d = 1'b0;
        end
        if (res_valid_q && bus.res_ready) begin
            txn_count_d = txn_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_id_q     <= '0;
            last_grant_q <= req_id_t'(NREQ - 1);
            txn_count_q  <= '0;
        end else begin
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_id_q     <= res_id_d;
            last_grant_q <= last_grant_d;
            txn_count_q  <= txn_count_d;
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_id    = res_id_q;
    assign txn_count     = txn_count_q;
endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed vector table, mid-stream reset, randomized run against a reference model, counter wrap.
module tb_logic_op_arbiter;
    logic        clk;
    logic        rst_n;
    logic [15:0] txn_count;

    logic_op_arbiter_if #(.WIDTH(8), .NREQ(4)) bus ();

    logic_op_arbiter #(.WIDTH(8), .NREQ(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .txn_count(txn_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        logic [3:0]  vld;
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        rdy;
        logic [3:0]  e_rdy;
        logic        e_vld;
        logic [7:0]  e_dat;
        logic [1:0]  e_id;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[16];

    // Reference model state
    logic        m_vld;
    logic [7:0]  m_dat;
    logic [1:0]  m_id;
    int          m_last;
    logic [15:0] m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(logic [3:0] vld, logic [7:0] op, logic [31:0] a, logic [31:0] b,
                                logic rdy, logic [3:0] e_rdy, logic e_vld, logic [7:0] e_dat,
                                logic [1:0] e_id, logic [15:0] e_cnt);
        vec_t v;
        v.vld = vld; v.op = op; v.a = a; v.b = b; v.rdy = rdy;
        v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_dat = e_dat; v.e_id = e_id; v.e_cnt = e_cnt;
        return v;
    endfunction

    function automatic logic [7:0] ref_op(logic [1:0] op, logic [7:0] a, logic [7:0] b);
        case (op)
            2'd0:    return ~a;
            2'd1:    return a & b;
            2'd2:    return a | b;
            default: return ~(a & b);
        endcase
    endfunction

    task automatic drive(input logic [3:0] vld, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic rdy);
        bus.req_valid = vld;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.res_ready = rdy;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(4'b0000, 8'h00, 32'h0, 32'h0, 1'b0);
        #1;
        check("reset_res_valid", {31'd0, bus.res_valid}, 32'd0);
        check("reset_txn_count", {16'd0, txn_count}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        tbl[0]  = mk(4'b1111, 8'hE4, 32'hF0F0F0F0, 32'h3C3C3C3C, 1'b1, 4'b0001, 1'b1, 8'h0F, 2'd0, 16'd0);
        tbl[1]  = mk(4'b1111, 8'hE4, 32'hF0F0F0F0, 32'h3C3C3C3C, 1'b1, 4'b0010, 1'b1, 8'h30, 2'd1, 16'd1);
        tbl[2]  = mk(4'b1111, 8'hE4, 32'hF0F0F0F0, 32'h3C3C3C3C, 1'b1, 4'b0100, 1'b1, 8'hFC, 2'd2, 16'd2);
        tbl[3]  = mk(4'b1111, 8'hE4, 32'hF0F0F0F0, 32'h3C3C3C3C, 1'b1, 4'b1000, 1'b1, 8'hCF, 2'd3, 16'd3);
        tbl[4]  = mk(4'b1111, 8'hE4, 32'hF0F0F0F0, 32'h3C3C3C3C, 1'b1, 4'b0001, 1'b1, 8'h0F, 2'd0, 16'd4);
        tbl[5]  = mk(4'b0100, 8'h10, 32'h00A50000, 32'h000F0000, 1'b1, 4'b0100, 1'b1, 8'h05, 2'd2, 16'd5);
        tbl[6]  = mk(4'b0000, 8'h00, 32'h00000000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h05, 2'd2, 16'd6);
        tbl[7]  = mk(4'b0001, 8'h00, 32'h0000005A, 32'h000000FF, 1'b1, 4'b0001, 1'b1, 8'hA5, 2'd0, 16'd6);
        for (int i = 8; i < 13; i++)
            tbl[i] = mk(4'b1010, 8'hE4, 32'hF0F0F0F0, 32'h3C3C3C3C, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd0, 16'd6);
        tbl[13] = mk(4'b1010, 8'hE4, 32'hF0F0F0F0, 32'h3C3C3C3C, 1'b1, 4'b0010, 1'b1, 8'h30, 2'd1, 16'd7);
        tbl[14] = mk(4'b1000, 8'hE4, 32'hF0F0F0F0, 32'h3C3C3C3C, 1'b1, 4'b1000, 1'b1, 8'hCF, 2'd3, 16'd8);
        tbl[15] = mk(4'b0000, 8'h00, 32'h00000000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'hCF, 2'd3, 16'd9);

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].vld, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rdy);
            #1;
            check($sformatf("tbl%0d_req_ready", i), {28'd0, bus.req_ready}, {28'd0, tbl[i].e_rdy});
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_res_valid", i), {31'd0, bus.res_valid}, {31'd0, tbl[i].e_vld});
            check($sformatf("tbl%0d_res_data", i),  {24'd0, bus.res_data},  {24'd0, tbl[i].e_dat});
            check($sformatf("tbl%0d_res_id", i),    {30'd0, bus.res_id},    {30'd0, tbl[i].e_id});
            check($sformatf("tbl%0d_txn_count", i), {16'd0, txn_count},     {16'd0, tbl[i].e_cnt});
        end

        // Reset in the middle of a stalled result, away from any clock edge
        drive(4'b1111, 8'hE4, 32'hF0F0F0F0, 32'h3C3C3C3C, 1'b0);
        @(posedge clk);
        #1;
        check("midrst_pre_valid", {31'd0, bus.res_valid}, 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        check("midrst_res_data",  {24'd0, bus.res_data},  32'd0);
        check("midrst_res_id",    {30'd0, bus.res_id},    32'd0);
        check("midrst_txn_count", {16'd0, txn_count},     32'd0);
        check("midrst_req_ready", {28'd0, bus.req_ready}, 32'd0);
        drive(4'b0000, 8'h00, 32'h0, 32'h0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        m_vld = 1'b0; m_dat = 8'h00; m_id = 2'd0; m_last = 3; m_cnt = 16'd0;
        for (int n = 0; n < 400; n++) begin
            logic [3:0]  v;
            logic [7:0]  op;
            logic [31:0] a, b;
            logic        rdy, acc;
            int          w;
            logic [3:0]  e_rdy;
            v   = 4'($urandom_range(0, 15));
            op  = 8'($urandom);
            a   = $urandom;
            b   = $urandom;
            rdy = ($urandom_range(0, 3) != 0);
            drive(v, op, a, b, rdy);
            #1;
            acc = !m_vld || rdy;
            w   = -1;
            for (int k = 1; k <= 4; k++) begin
                if (w < 0 && v[(m_last + k) % 4]) w = (m_last + k) % 4;
            end
            e_rdy = (acc && w >= 0) ? 4'(1 << w) : 4'b0000;
            check("rnd_req_ready", {28'd0, bus.req_ready}, {28'd0, e_rdy});
            check("rnd_res_valid", {31'd0, bus.res_valid}, {31'd0, m_vld});
            check("rnd_res_data",  {24'd0, bus.res_data},  {24'd0, m_dat});
            check("rnd_res_id",    {30'd0, bus.res_id},    {30'd0, m_id});
            check("rnd_txn_count", {16'd0, txn_count},     {16'd0, m_cnt});
            if (m_vld && rdy) m_cnt = m_cnt + 16'd1;
            if (acc && w >= 0) begin
                m_vld  = 1'b1;
                m_dat  = ref_op(op[2*w +: 2], a[8*w +: 8], b[8*w +: 8]);
                m_id   = 2'(w);
                m_last = w;
            end else if (acc) begin
                m_vld = 1'b0;
            end
            @(posedge clk);
            #1;
        end

        // Counter wrap: drain, load one result, force the count to its top value, then drain it
        drive(4'b0000, 8'h00, 32'h0, 32'h0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        drive(4'b0001, 8'h01, 32'h000000FF, 32'h0000000F, 1'b1);
        @(posedge clk);
        #1;
        drive(4'b0000, 8'h00, 32'h0, 32'h0, 1'b1);
        force dut.txn_count_q = 16'hFFFF;
        #1;
        release dut.txn_count_q;
        #1;
        check("wrap_before", {16'd0, txn_count}, 32'h0000FFFF);
        check("wrap_res_valid", {31'd0, bus.res_valid}, 32'd1);
        @(posedge clk);
        #1;
        check("wrap_after", {16'd0, txn_count}, 32'h00000000);
        check("wrap_drained", {31'd0, bus.res_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/logic_op_arbiter.md
# logic_op_arbiter

Round-robin arbiter and sequencer that shares one bitwise logic unit (NOT/AND/OR/NAND) among four requesters. Each requester presents an opcode and two operands over a valid/ready handshake. The arbiter grants one request per cycle into a single-entry registered result stage that returns the result tagged with the requester ID. It sits between the gate-level primitives and any higher-level block needing time-shared bitwise operations.

## Interface
Parameters:
- WIDTH, 8: operand and result width in bits.
- NREQ, 4: number of requesters; fixed at 4 for this revision.

Ports:
- clk  input  1: single clock; all state updates on the rising edge.
- rst_n  input  1: asynchronous reset, active-low.
- req_valid  input  NREQ: request valid, one bit per requester.
- req_ready  output  NREQ: request accepted this cycle; one-hot or zero.
- req_op  input  2*NREQ: opcode per requester, slice i at [2i+1:2i]. 00 NOT a, 01 AND, 10 OR, 11 NAND.
- req_a  input  WIDTH*NREQ: operand A per requester, slice i.
- req_b  input  WIDTH*NREQ: operand B per requester, slice i; ignored for NOT.
- res_valid  output  1: result register holds a valid result.
- res_ready  input  1: downstream accepts the result.
- res_data  output  WIDTH: operation result.
- res_id  output  2: index of the requester that produced res_data.
- txn_count  output  16: number of completed result handshakes; wraps at 0xFFFF to 0.

## Operation
- Accept condition: accept = !res_valid || res_ready. The result slot is either empty or drains this cycle.
- Arbitration:
  - Round-robin over the requesters with req_valid set.
  - The search starts at last_grant+1 mod 4.
  - The winner's req_ready is 1 only when accept is 1. Otherwise all req_ready bits are 0.
  - req_ready depends combinationally on req_valid and res_ready. Requesters must not make req_valid depend on req_ready.
- Transfer: a request transfers when req_valid[i] && req_ready[i]. On transfer:
  - res_data is loaded with op(a_i, b_i).
  - res_id is loaded with i.
  - res_valid is set to 1.
  - last_grant is updated to i.
- Drain: if res_valid && res_ready and no new request transfers, res_valid clears. res_data and res_id hold their old values.
- Simultaneous drain and accept: the new result replaces the old one in the same cycle, giving throughput of one per cycle.
- Backpressure: when res_valid && !res_ready:
  - res_data and res_id are held stable.
  - All req_ready bits are 0.
  - last_grant is unchanged.
- txn_count increments by 1 on each cycle where res_valid && res_ready.
- Requester state: a requester that is not granted keeps its request pending. The arbiter stores no per-requester state beyond last_grant.
- Reset values, applied asynchronously on rst_n=0:
  - res_valid 0, res_data 0, res_id 0, txn_count 0.
  - last_grant 3, so requester 0 has highest priority first.
  - req_ready is 0 while in reset.
- Reset mid-operation: any pending result is discarded and the arbiter restarts from the reset values. No handshake completes during reset.

## Timing
- Latency: a request accepted at edge N shows res_valid=1 with its result after edge N, i.e. one cycle.
- Throughput: one result per cycle when res_ready is held at 1.
- Fairness: with all four requesters continuously valid, grants rotate 0,1,2,3,0,…; each requester waits at most 3 grants.
- Arithmetic: all ops are bitwise on WIDTH bits, with no carry or extension.
- txn_count wraps modulo 2^16.

## Structure
- Shared package logic_op_pkg:
  - opcode constants OP_NOT=2'b00, OP_AND=2'b01, OP_OR=2'b10, OP_NAND=2'b11;
  - requester-ID width constant (2).
- Sub-module bitwise_logic_unit: purely combinational.
  - Inputs op, a, b; output y.
  - Built from the team's existing inverter/andgate/orgate/nandgate cells, replicated per bit, with a 4:1 select on op.
- Top level contains:
  - round-robin grant logic (rotate, priority-pick, un-rotate);
  - result register;
  - last_grant register;
  - txn_count.

## Test plan
- Reset: assert rst_n=0 mid-stream → res_valid=0, res_data=0, res_id=0, txn_count=0, req_ready=0000 immediately, without waiting for a clock edge.
- Single request: requester 2, op AND, a=0xA5, b=0x0F, res_ready=1.
  - Required response: req_ready=0100 in that cycle; next cycle res_valid=1, res_data=0x05, res_id=2; txn_count=1 after the drain.
- All four requesters valid continuously, each with a distinct op on a=0xF0, b=0x3C, res_ready=1.
  - Grant order is 0,1,2,3,0.
  - Results in order: NOT 0x0F, AND 0x30, OR 0xFC, NAND 0xCF, with matching res_id.
- Backpressure: hold res_ready=0 for 5 cycles while requests 1 and 3 are pending.
  - res_data and res_id stay stable and req_ready=0000.
  - On release: one result per cycle, requester 1 then requester 3.
- NOT ignores b: requester 0, op NOT, a=0x5A, b=0xFF → res_data=0xA5.
- Counter wrap: preload txn_count near 0xFFFF through a long run, or force it in the bench → 0xFFFF followed by a handshake gives 0x0000.
